// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, schedules EX branch redirects, and counts stall cycles and flushes.
module pipe_ctrl #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             branch_flag,
  input  logic [PC_W-1:0]  branch_target,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [PC_W-1:0]  new_pc,
  output logic             redirect,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic {IDLE, WAIT_IF} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] pend_pc;
  logic waiting, accept, defer;
  always_comb begin
    waiting = state == WAIT_IF;
    stall = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
            stallreq_id  ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    stall = waiting ? (stall | 6'b000011) : stall;
    accept = !waiting && branch_flag && !stall[3];
    defer = accept && stallreq_if;
    flush = accept || (waiting && !stallreq_if);
    redirect = !stallreq_if && (accept || waiting);
    new_pc = !redirect ? '0 : waiting ? pend_pc : branch_target;
    redirect_pending = waiting;
    state_nx = defer ? WAIT_IF : (waiting && !stallreq_if) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pend_pc <= '0;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nx;
      if (defer) pend_pc <= branch_target;
      if (stall[0] && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against a behavioural reference model.
module tb_pipe_ctrl;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, rst = 0, sif = 0, sid = 0, sex = 0, smem = 0, bf = 0;
  logic [31:0] bt = 0;
  logic [5:0] stall;
  logic flush, redirect, redirect_pending;
  logic [31:0] new_pc;
  logic [CW-1:0] stall_cycles, flush_count;
  always #5 clk = ~clk;
  pipe_ctrl #(.CNT_W(CW), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
    .stallreq_mem(smem), .branch_flag(bf), .branch_target(bt), .stall(stall),
    .flush(flush), .new_pc(new_pc), .redirect(redirect), .redirect_pending(redirect_pending),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  typedef struct packed {
    logic [5:0] stall;
    logic flush, redirect;
    logic [31:0] new_pc;
    logic pend;
    logic [CW-1:0] sc, fc;
  } out_t;
  int tests = 0, fails = 0;
  logic m_pend = 0;
  logic [31:0] m_ppc = 0;
  int m_sc = 0, m_fc = 0;
  out_t e;
  int fc0;
  // EX must hold a bubble while a redirect is pending
  always @(negedge clk) if (rst) assert (!(redirect_pending && bf)) else $error("branch_flag during WAIT_IF");
  // stall is a prefix of ones covering every stage up to the deepest requester
  function automatic out_t model();
    out_t o;
    int k;
    logic acc;
    k = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
    if (m_pend && k < 2) k = 2;
    o.stall = 6'((1 << k) - 1);
    acc = !m_pend && bf && k < 4;
    o.flush = acc || (m_pend && !sif);
    o.redirect = !sif && (acc || m_pend);
    o.new_pc = !o.redirect ? 32'd0 : m_pend ? m_ppc : bt;
    o.pend = m_pend;
    o.sc = CW'(m_sc);
    o.fc = CW'(m_fc);
    return o;
  endfunction
  function automatic out_t dut_out();
    return {stall, flush, redirect, new_pc, redirect_pending, stall_cycles, flush_count};
  endfunction
  task automatic advance();
    out_t x;
    x = model();
    if (x.stall[0] && m_sc < SAT) m_sc++;
    if (x.flush && m_fc < SAT) m_fc++;
    if (!m_pend && x.flush && sif) begin
      m_pend = 1;
      m_ppc = bt;
    end else if (m_pend && !sif) m_pend = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic i, d, x, m, b, input logic [31:0] t);
    {sif, sid, sex, smem, bf, bt} = {i, d, x, m, b, t};
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0);
    m_pend = 0; m_ppc = 0; m_sc = 0; m_fc = 0;
    @(posedge clk);
    #2 rst = 1;
  endtask
  task automatic test_reset();
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0);
    #3;
    tests++;
    if (dut_out() !== '0) begin fails++; $display("FAIL reset: got %h exp 0", dut_out()); end
    do_reset();
    @(negedge clk);
    e = model();
    tests++;
    if (dut_out() !== e) begin fails++; $display("FAIL reset_release: got %h exp %h", dut_out(), e); end
    advance();
  endtask
  task automatic test_priority();
    logic [5:0] pat [3];
    pat = '{6'b011111, 6'b000111, 6'b000000};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_in(1, 0, 0, 1, 0, 0);
      else if (i == 1) set_in(0, 1, 0, 0, 0, 0);
      else set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      e = model();
      tests++;
      if (stall !== pat[i] || dut_out() !== e) begin
        fails++; $display("FAIL priority%0d: stall %b exp %b, out %h exp %h", i, stall, pat[i], dut_out(), e);
      end
      advance();
    end
  endtask
  task automatic test_clean_branch();
    set_in(0, 0, 0, 0, 1, 32'h0000_1040);
    fc0 = m_fc;
    @(negedge clk);
    e = model();
    tests++;
    if ({flush, redirect, new_pc} !== {2'b11, 32'h0000_1040} || dut_out() !== e) begin
      fails++; $display("FAIL clean_branch: got %h exp %h", dut_out(), e);
    end
    advance();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (flush_count !== CW'(fc0 + 1) || redirect !== 1'b0) begin
      fails++; $display("FAIL clean_branch_count: flush_count %0d exp %0d", flush_count, fc0 + 1);
    end
    advance();
  endtask
  task automatic test_blocked_branch();
    set_in(0, 0, 1, 0, 1, 32'h0000_3000);
    @(negedge clk);
    e = model();
    tests++;
    if ({flush, redirect} !== 2'b00 || dut_out() !== e) begin
      fails++; $display("FAIL blocked_branch: got %h exp %h", dut_out(), e);
    end
    advance();
    sex = 0;
    @(negedge clk);
    e = model();
    tests++;
    if ({flush, redirect, new_pc} !== {2'b11, 32'h0000_3000} || dut_out() !== e) begin
      fails++; $display("FAIL blocked_release: got %h exp %h", dut_out(), e);
    end
    advance();
    set_in(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_deferred();
    set_in(1, 0, 0, 0, 1, 32'h0000_2000);
    fc0 = m_fc;
    @(negedge clk);
    e = model();
    tests++;
    if ({flush, redirect, redirect_pending} !== 3'b100 || dut_out() !== e) begin
      fails++; $display("FAIL deferred_accept: got %h exp %h", dut_out(), e);
    end
    advance();
    set_in(1, 0, 0, 0, 0, 32'hdead_beef);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = model();
      tests++;
      if ({redirect_pending, flush, redirect, stall} !== {3'b100, 6'b000011} || dut_out() !== e) begin
        fails++; $display("FAIL deferred_wait%0d: got %h exp %h", i, dut_out(), e);
      end
      advance();
    end
    sif = 0;
    @(negedge clk);
    e = model();
    tests++;
    if ({flush, redirect, new_pc} !== {2'b11, 32'h0000_2000} || dut_out() !== e) begin
      fails++; $display("FAIL deferred_fire: got %h exp %h", dut_out(), e);
    end
    advance();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (redirect_pending !== 1'b0 || flush_count !== CW'(fc0 + 2)) begin
      fails++; $display("FAIL deferred_done: pending %b flush_count %0d exp 0 %0d", redirect_pending, flush_count, fc0 + 2);
    end
  endtask
  task automatic test_reset_wait_if();
    set_in(1, 0, 0, 0, 1, 32'h0000_5000);
    advance();
    bf = 0;
    #2 rst = 0;
    #1;
    m_pend = 0; m_ppc = 0; m_sc = 0; m_fc = 0;
    tests++;
    if ({redirect_pending, stall_cycles, flush_count} !== '0) begin
      fails++; $display("FAIL reset_wait_if: pending %b sc %0d fc %0d exp 0", redirect_pending, stall_cycles, flush_count);
    end
    rst = 1;
    sif = 0;
    @(negedge clk);
    e = model();
    tests++;
    if ({flush, redirect} !== 2'b00 || dut_out() !== e) begin
      fails++; $display("FAIL reset_wait_if_release: got %h exp %h", dut_out(), e);
    end
    advance();
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 7) == 0), m_pend ? 1'b0 : ($urandom_range(0, 2) == 0), $urandom);
      @(negedge clk);
      e = model();
      tests++;
      if (dut_out() !== e) begin fails++; $display("FAIL random%0d: got %h exp %h", i, dut_out(), e); end
      advance();
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_saturation();
    do_reset();
    smem = 1;
    repeat (20) advance();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = model();
      tests++;
      if (stall_cycles !== CW'(SAT) || dut_out() !== e) begin
        fails++; $display("FAIL saturation%0d: stall_cycles %0d exp %0d", i, stall_cycles, SAT);
      end
      advance();
    end
    smem = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_priority();
    test_clean_branch();
    test_blocked_branch();
    test_deferred();
    test_reset_wait_if();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
